// File: rtl/axi_tg_pkg.sv
// Shared AXI encodings and reader FSM states for the DDR
// traffic generator / frame reader pair.
package axi_tg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;
  localparam logic [2:0] AXI_PROT_NONE  = 3'b000;
  localparam logic [3:0] AXI_QOS_NONE   = 4'b0000;

endpackage

// File: rtl/axi_rd_skid.sv
// Two-entry skid buffer on the R -> pixel path; ready depends
// only on occupancy, output data is registered.
module axi_rd_skid #(
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_q;
  logic              rd_q;
  logic [1:0]        cnt_q;
  logic              push;
  logic              pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_q];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= in_data_i;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axi_frame_reader.sv
// AXI3 read-burst master sweeping a frame buffer in DDR and
// streaming the returned beats to a pixel consumer.
module axi_frame_reader
  import axi_tg_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 64,
  parameter int              BURST_LEN  = 15,
  parameter logic [ADDR_W-1:0] ADDR_START = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] ADDR_END   = 32'h107E_8F80
) (
  input  logic              aclk,
  input  logic              areset,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [3:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic              start,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              busy,
  output logic              err_resp,
  output logic              err_last
);

  localparam int STEP = (BURST_LEN + 1) * DATA_W / 8;
  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);
  localparam logic [3:0] LAST_CNT = 4'(BURST_LEN);

  if ((((ADDR_END - ADDR_START) % STEP_A) != '0) || (BURST_LEN > 15)) begin : g_bad_cfg
    $error("axi_frame_reader: bad frame/burst geometry");
  end

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_resp_q, err_resp_d;
  logic              err_last_q, err_last_d;
  logic              done_q, done_d;
  logic              skid_ready;
  logic              beat;
  logic              at_last;

  assign m_axi_arlen   = LAST_CNT;
  assign m_axi_arsize  = 3'($clog2(DATA_W / 8));
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arcache = AXI_CACHE_BUF;
  assign m_axi_arprot  = AXI_PROT_NONE;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arqos   = AXI_QOS_NONE;

  assign m_axi_arvalid = (state_q == ST_ADDR);
  assign m_axi_araddr  = m_axi_arvalid ? addr_q : '0;
  assign m_axi_rready  = (state_q == ST_DATA) & skid_ready;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = done_q;
  assign err_resp      = err_resp_q;
  assign err_last      = err_last_q;

  assign beat    = m_axi_rvalid & m_axi_rready;
  assign at_last = (cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_resp_d = err_resp_q;
    err_last_d = err_last_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_ADDR;
      ST_ADDR: if (m_axi_arready) state_d = ST_DATA;
      ST_DATA: if (beat && at_last) state_d = start ? ST_ADDR : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (beat) begin
      cnt_d = at_last ? 4'd0 : cnt_q + 4'd1;
      if (m_axi_rresp != AXI_RESP_OKAY) err_resp_d = 1'b1;
      if (m_axi_rlast != at_last) err_last_d = 1'b1;
      // burst length is trusted over rlast
      if (at_last) begin
        if (addr_q == ADDR_END) begin
          addr_d = ADDR_START;
          done_d = 1'b1;
        end else begin
          addr_d = addr_q + STEP_A;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      addr_q     <= ADDR_START;
      cnt_q      <= 4'd0;
      err_resp_q <= 1'b0;
      err_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      err_resp_q <= err_resp_d;
      err_last_q <= err_last_d;
      done_q     <= done_d;
    end
  end

  axi_rd_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk_i      (aclk),
    .rst_i      (areset),
    .in_valid_i (beat),
    .in_data_i  (m_axi_rdata),
    .in_ready_o (skid_ready),
    .out_valid_o(pix_valid),
    .out_data_o (pix_data),
    .out_ready_i(pix_ready)
  );

endmodule

// File: tb/tb_axi_frame_reader.sv
// Frame reader bench: random AXI slave, pixel scoreboard and
// address/flag model on a three-burst frame.
module tb_axi_frame_reader;

  localparam logic [31:0] START = 32'h1000_0000;
  localparam logic [31:0] FEND  = 32'h1000_0100;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arlock;
  logic [3:0]  arqos;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        start = 1'b0;
  logic [63:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        frame_done;
  logic        busy;
  logic        err_resp;
  logic        err_last;

  always #5 clk = ~clk;

  axi_frame_reader #(
    .ADDR_W    (32),
    .DATA_W    (64),
    .BURST_LEN (15),
    .ADDR_START(START),
    .ADDR_END  (FEND)
  ) dut (
    .aclk         (clk),
    .areset       (areset),
    .m_axi_araddr (araddr),
    .m_axi_arlen  (arlen),
    .m_axi_arsize (arsize),
    .m_axi_arburst(arburst),
    .m_axi_arcache(arcache),
    .m_axi_arprot (arprot),
    .m_axi_arlock (arlock),
    .m_axi_arqos  (arqos),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rlast  (rlast),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready),
    .start        (start),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .frame_done   (frame_done),
    .busy         (busy),
    .err_resp     (err_resp),
    .err_last     (err_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // slave configuration
  int cfg_ar_hold = 0;
  int cfg_err_beat = 99;
  int cfg_last_beat = 15;
  bit r_full = 1'b1;
  int pix_mode = 0;

  // slave state
  bit s_dat = 0;
  int s_beat = 0;
  bit ar_pend = 0;
  bit r_pend = 0;
  int hold = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (areset) begin
        s_dat = 0; ar_pend = 0; r_pend = 0;
        arready = 0; rvalid = 0; rlast = 0;
        hold = cfg_ar_hold;
      end else begin
        if (ar_pend) begin s_dat = 1; s_beat = 0; end
        if (r_pend) begin
          rvalid = 0;
          s_beat++;
          if (s_beat == 16) begin s_dat = 0; hold = cfg_ar_hold; end
        end
        ar_pend = 0; r_pend = 0; arready = 0;
        if (!s_dat) begin
          if (arvalid) begin
            if (hold > 0) hold--;
            else begin arready = 1; ar_pend = 1; end
          end
        end else begin
          if (!rvalid && (r_full || $urandom_range(3) != 0)) begin
            rvalid = 1;
            rdata  = {$urandom, $urandom};
            rresp  = (s_beat == cfg_err_beat) ? 2'b10 : 2'b00;
            rlast  = (s_beat == cfg_last_beat);
          end
          r_pend = rvalid & rready;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (pix_mode == 0) pix_ready = 1'b1;
      else if (pix_mode == 1) pix_ready = ~pix_ready;
      else pix_ready = 1'($urandom_range(1));
    end
  end

  // reference model and scoreboard
  logic [63:0] exp_q[$];
  int occ = 0, rb = 0, burst_idx = 0;
  int ar_cnt = 0, ar_stall = 0, bursts_done = 0, pix_cnt = 0;
  int frames = 0, exp_frames = 0;
  bit exp_err_resp = 0, exp_err_last = 0;
  bit hold_ar = 0, hold_pix = 0, fd_prev = 0;
  logic [31:0] hold_addr, cur_addr, last_ar_addr;
  logic [63:0] hold_data;

  always @(negedge clk) begin
    if (areset) begin
      exp_q.delete();
      occ = 0; rb = 0; burst_idx = 0;
      exp_err_resp = 0; exp_err_last = 0;
      hold_ar = 0; hold_pix = 0; fd_prev = 0;
    end else begin
      if (hold_ar) begin
        chk("ar_hold_valid", arvalid, 1);
        chk("ar_hold_addr", araddr, hold_addr);
      end
      hold_ar = arvalid & ~arready;
      hold_addr = araddr;
      if (arvalid & ~arready) ar_stall++;
      if (arvalid & arready) begin
        chk("ar_addr", araddr, START + 32'((burst_idx % 3) * 128));
        chk("ar_len", arlen, 15);
        chk("ar_after_16", rb, 0);
        cur_addr = araddr;
        last_ar_addr = araddr;
        burst_idx++;
        ar_cnt++;
      end
      if (occ == 2) chk("rready_full", rready, 0);
      chk("pix_valid_occ", pix_valid, occ > 0);
      if (hold_pix) begin
        chk("pix_hold_valid", pix_valid, 1);
        chk("pix_hold_data", pix_data, hold_data);
      end
      hold_pix = pix_valid & ~pix_ready;
      hold_data = pix_data;
      if (pix_valid & pix_ready) begin
        chk("pix_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("pix_data", pix_data, exp_q.pop_front());
        pix_cnt++;
        occ--;
      end
      if (rvalid & rready) begin
        exp_q.push_back(rdata);
        if (rresp != 2'b00) exp_err_resp = 1;
        if (rlast != (rb == 15)) exp_err_last = 1;
        rb++;
        occ++;
        if (rb == 16) begin
          rb = 0;
          bursts_done++;
          if (cur_addr == FEND) exp_frames++;
        end
      end
      if (frame_done) begin
        frames++;
        chk("fd_pulse", fd_prev, 0);
      end
      fd_prev = frame_done;
    end
  end

  int t, n0, b0, s0;

  task automatic tmo(input string tag, input bit ok);
    chk(tag, ok, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rready", rready, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_resp", err_resp, 0);
    chk("rst_err_last", err_last, 0);
    chk("rst_arlen", arlen, 15);
    chk("rst_arsize", arsize, 3);
    chk("rst_arburst", arburst, 1);
    chk("rst_arcache", arcache, 3);
    chk("rst_misc", {arprot, arlock, arqos}, 0);
    areset = 0;

    // full rate, first burst
    start = 1;
    t = 0;
    while (!(pix_cnt >= 16 && ar_cnt >= 2) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    tmo("to_first_burst", pix_cnt >= 16 && ar_cnt >= 2);
    chk("second_ar_addr", last_ar_addr, START + 32'h80);
    chk("err_resp_clean", err_resp, 0);
    chk("err_last_clean", err_last, 0);

    // toggling consumer, random slave gaps, frame wrap
    pix_mode = 1; r_full = 0;
    b0 = bursts_done;
    t = 0;
    while (bursts_done < b0 + 4 && t < 4000) begin
      @(posedge clk); #1; t++;
    end
    tmo("to_toggle", bursts_done >= b0 + 4);
    repeat (2) @(posedge clk); #1;
    chk("frames_seen", frames, exp_frames);
    chk("frame_nonzero", frames >= 1, 1);

    // slave stalls AR for 5 cycles
    cfg_ar_hold = 5;
    s0 = ar_stall; b0 = bursts_done; n0 = ar_cnt;
    t = 0;
    while (bursts_done < b0 + 2 && t < 4000) begin
      @(posedge clk); #1; t++;
    end
    tmo("to_ar_hold", bursts_done >= b0 + 2);
    cfg_ar_hold = 0;
    chk("ar_stall_cycles", (ar_stall - s0) >= 5, 1);
    chk("ar_one_per_burst", ar_cnt - n0 <= 3, 1);

    // bad response and early rlast
    pix_mode = 2;
    cfg_err_beat = 3; cfg_last_beat = 10;
    b0 = bursts_done;
    t = 0;
    while (bursts_done < b0 + 2 && t < 4000) begin
      @(posedge clk); #1; t++;
    end
    tmo("to_err", bursts_done >= b0 + 2);
    cfg_err_beat = 99; cfg_last_beat = 15;
    @(posedge clk); #1;
    chk("err_resp_set", err_resp, 1);
    chk("err_resp_model", err_resp, exp_err_resp);
    chk("err_last_set", err_last, 1);
    chk("err_last_model", err_last, exp_err_last);
    b0 = bursts_done;
    t = 0;
    while (bursts_done < b0 + 2 && t < 4000) begin
      @(posedge clk); #1; t++;
    end
    tmo("to_sticky", bursts_done >= b0 + 2);
    chk("err_resp_sticky", err_resp, 1);
    chk("err_last_sticky", err_last, 1);

    // start dropped mid-burst
    t = 0;
    while (!(s_dat && s_beat == 8) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    tmo("to_beat8", s_dat && s_beat == 8);
    start = 0;
    t = 0;
    while (busy && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    tmo("to_idle", !busy);
    n0 = ar_cnt;
    repeat (20) @(posedge clk); #1;
    chk("no_ar_after_stop", ar_cnt, n0);
    chk("stop_arvalid", arvalid, 0);
    chk("stop_burst_whole", rb, 0);
    chk("stop_drained", pix_cnt % 16, 0);

    // reset mid-burst
    start = 1;
    t = 0;
    while (!(s_dat && s_beat == 5) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    tmo("to_beat5", s_dat && s_beat == 5);
    areset = 1;
    repeat (2) @(posedge clk); #1;
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pix_valid", pix_valid, 0);
    chk("mid_rst_err_resp", err_resp, 0);
    chk("mid_rst_err_last", err_last, 0);
    areset = 0;
    n0 = ar_cnt; b0 = bursts_done;
    t = 0;
    while (bursts_done < b0 + 1 && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    tmo("to_post_rst", bursts_done >= b0 + 1);
    chk("post_rst_ar", ar_cnt > n0, 1);
    start = 0;
    t = 0;
    while (busy && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    tmo("to_final_idle", !busy);
    repeat (10) @(posedge clk); #1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
